// File: rtl/mem_copy_engine_if.sv
// -----------------------------------------------------------------------------
// mem_copy_engine_if
// Memory request bus between an initiator (mem_copy_engine) and a responder.
//
// Ports / signals:
//   mem_req_o    : request (initiator -> responder)
//   mem_addr_o   : request address, word aligned
//   mem_we_o     : 1 = write, 0 = read
//   mem_be_o     : byte enables, all-ones whenever mem_req_o is high
//   mem_wdata_o  : write data
//   mem_rvalid_i : transaction complete (read data valid / write acknowledge)
//   mem_err_i    : transaction failed
//   mem_rdata_i  : read data, valid with mem_rvalid_i
//
// Handshake: mem_req_o acts as valid and mem_rvalid_i/mem_err_i act as the
// completion. Once mem_req_o rises, addr/we/be/wdata hold still until the cycle
// in which the responder raises mem_rvalid_i or mem_err_i; that cycle completes
// the transaction. Responses are only meaningful while mem_req_o is high, and
// the initiator drops mem_req_o for at least one cycle between transactions.
// -----------------------------------------------------------------------------
interface mem_copy_engine_if #(
  parameter int MEM_W = 32
);
  logic               mem_req_o;
  logic [31:0]        mem_addr_o;
  logic               mem_we_o;
  logic [MEM_W/8-1:0] mem_be_o;
  logic [MEM_W-1:0]   mem_wdata_o;
  logic               mem_rvalid_i;
  logic               mem_err_i;
  logic [MEM_W-1:0]   mem_rdata_i;

  modport master (
    output mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
    input  mem_rvalid_i, mem_err_i, mem_rdata_i
  );

  modport slave (
    input  mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
    output mem_rvalid_i, mem_err_i, mem_rdata_i
  );
endinterface

// File: rtl/mem_copy_engine.sv
// -----------------------------------------------------------------------------
// mem_copy_engine
// Copies word_count words from src_addr to dst_addr, one transaction at a time:
// read a word, drop the request for one cycle, write it, drop the request for
// one cycle, repeat.
//
// Optional feature: define MEM_COPY_TIMEOUT_EN to abort a transaction whose
// request has been outstanding for TIMEOUT_CYCLES cycles with no response.
//
// Ports:
//   clk          : clock, all state on posedge
//   rst          : asynchronous active-low reset
//   start        : one-cycle launch pulse, ignored unless idle
//   src_addr     : source start address (word aligned)
//   dst_addr     : destination start address (word aligned)
//   word_count   : words to copy, 0..1024
//   busy         : copy in progress
//   done         : one-cycle pulse on successful completion
//   error        : sticky failure flag, cleared by the next accepted start
//   err_addr     : failing transaction address or misaligned address
//   o_dbg_state  : current FSM state encoding
//   bus          : memory request bus (master side)
// -----------------------------------------------------------------------------
module mem_copy_engine #(
  parameter int MEM_W          = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       src_addr,
  input  logic [31:0]       dst_addr,
  input  logic [10:0]       word_count,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [31:0]       err_addr,
  output logic [2:0]        o_dbg_state,
  mem_copy_engine_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READ   = 3'd1,
    S_WRITE  = 3'd2,
    S_GAP    = 3'd3,
    S_FINISH = 3'd4,
    S_FAIL   = 3'd5
  } state_t;

  localparam logic [31:0] ADDR_STEP = 32'(MEM_W / 8);

  state_t           r_state;
  logic             r_next_write;
  logic [31:0]      r_src;
  logic [31:0]      r_dst;
  logic [31:0]      r_addr;
  logic [31:0]      r_err_addr;
  logic [10:0]      r_remaining;
  logic [MEM_W-1:0] r_data;
  logic             r_req;
  logic             r_we;
  logic             r_busy;
  logic             r_done;
  logic             r_error;
  logic             w_timeout;

`ifdef MEM_COPY_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] r_tmo;

  // Counts request cycles of the current transaction; any response (or the
  // request dropping in GAP) restarts it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tmo <= '0;
    end else if (r_req && !bus.mem_rvalid_i && !bus.mem_err_i && !w_timeout) begin
      r_tmo <= r_tmo + 1'b1;
    end else begin
      r_tmo <= '0;
    end
  end

  // True during the TIMEOUT_CYCLES-th request cycle without a response.
  assign w_timeout = r_req && (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_next_write <= 1'b0;
      r_src        <= '0;
      r_dst        <= '0;
      r_addr       <= '0;
      r_err_addr   <= '0;
      r_remaining  <= '0;
      r_data       <= '0;
      r_req        <= 1'b0;
      r_we         <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_src       <= src_addr;
            r_dst       <= dst_addr;
            r_remaining <= word_count;
            r_error     <= 1'b0;
            // Source is checked before destination; neither case touches the bus.
            if (src_addr[1:0] != 2'b00) begin
              r_err_addr <= src_addr;
              r_error    <= 1'b1;
              r_state    <= S_FAIL;
            end else if (dst_addr[1:0] != 2'b00) begin
              r_err_addr <= dst_addr;
              r_error    <= 1'b1;
              r_state    <= S_FAIL;
            end else if (word_count == 11'd0) begin
              r_done  <= 1'b1;
              r_state <= S_FINISH;
            end else begin
              r_busy  <= 1'b1;
              r_req   <= 1'b1;
              r_we    <= 1'b0;
              r_addr  <= src_addr;
              r_state <= S_READ;
            end
          end
        end

        S_READ, S_WRITE: begin
          // A bus error outranks a simultaneous rvalid.
          if (bus.mem_err_i || (!bus.mem_rvalid_i && w_timeout)) begin
            r_err_addr <= r_addr;
            r_error    <= 1'b1;
            r_req      <= 1'b0;
            r_we       <= 1'b0;
            r_busy     <= 1'b0;
            r_state    <= S_FAIL;
          end else if (bus.mem_rvalid_i) begin
            r_req <= 1'b0;
            if (r_state == S_READ) begin
              r_data       <= bus.mem_rdata_i;
              r_next_write <= 1'b1;
              r_state      <= S_GAP;
            end else begin
              r_src       <= r_src + ADDR_STEP;
              r_dst       <= r_dst + ADDR_STEP;
              r_remaining <= r_remaining - 1'b1;
              if (r_remaining == 11'd1) begin
                r_we    <= 1'b0;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_state <= S_FINISH;
              end else begin
                r_next_write <= 1'b0;
                r_state      <= S_GAP;
              end
            end
          end
        end

        // One request-low cycle, then launch whichever operation is next.
        S_GAP: begin
          r_req <= 1'b1;
          if (r_next_write) begin
            r_we    <= 1'b1;
            r_addr  <= r_dst;
            r_state <= S_WRITE;
          end else begin
            r_we    <= 1'b0;
            r_addr  <= r_src;
            r_state <= S_READ;
          end
        end

        S_FINISH: r_state <= S_IDLE;
        S_FAIL:   r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  assign busy            = r_busy;
  assign done            = r_done;
  assign error           = r_error;
  assign err_addr        = r_err_addr;
  assign o_dbg_state     = r_state;
  assign bus.mem_req_o   = r_req;
  assign bus.mem_addr_o  = r_addr;
  assign bus.mem_we_o    = r_we;
  assign bus.mem_be_o    = {(MEM_W/8){r_req}};
  assign bus.mem_wdata_o = r_data;

endmodule

// File: tb/tb_mem_copy_engine.sv
// -----------------------------------------------------------------------------
// tb_mem_copy_engine
// Bench for mem_copy_engine: a behavioural responder with configurable latency,
// error injection and a silent mode; expected bus transactions are queued as
// each copy is launched and compared as the engine issues them.
// -----------------------------------------------------------------------------
module tb_mem_copy_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] src_addr;
  logic [31:0] dst_addr;
  logic [10:0] word_count;
  logic        busy;
  logic        done;
  logic        error;
  logic [31:0] err_addr;
  logic [2:0]  dbg_state;

  mem_copy_engine_if #(.MEM_W(32)) bus ();

`ifdef MEM_COPY_TIMEOUT_EN
  mem_copy_engine #(.MEM_W(32), .TIMEOUT_CYCLES(16)) dut (
`else
  mem_copy_engine #(.MEM_W(32)) dut (
`endif
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .src_addr    (src_addr),
    .dst_addr    (dst_addr),
    .word_count  (word_count),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .err_addr    (err_addr),
    .o_dbg_state (dbg_state),
    .bus         (bus)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  // {we, addr, wdata}; wdata field is 0 for reads
  logic [64:0] exp_q[$];

  int          resp_delay   = 1;
  bit          silent       = 1'b0;
  bit          inject       = 1'b0;
  logic [31:0] inj_addr     = '0;
  logic [31:0] rd_base_addr = '0;
  logic [31:0] rd_base_data = '0;

  int req_count   = 0;
  int done_cnt    = 0;
  int req_hi_cnt  = 0;

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (bus.mem_req_o === 1'b1) req_hi_cnt++;
  end

  task automatic push_rd(input logic [31:0] a);
    exp_q.push_back({1'b0, a, 32'h0});
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
    exp_q.push_back({1'b1, a, d});
  endtask

  // ---------------- responder + scoreboard ----------------
  initial begin
    logic        prev_req;
    logic        resp_given;
    int          age;
    logic [31:0] cur_addr;
    logic        cur_we;
    logic [31:0] cur_wdata;
    logic [64:0] obs;
    logic [64:0] exp;
    prev_req   = 1'b0;
    resp_given = 1'b0;
    age        = 0;
    cur_addr   = '0;
    cur_we     = 1'b0;
    cur_wdata  = '0;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_err_i    = 1'b0;
    bus.mem_rdata_i  = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.mem_rvalid_i = 1'b0;
      bus.mem_err_i    = 1'b0;
      if (resp_given) begin
        checks++;
        if (bus.mem_req_o !== 1'b0) begin
          errors++;
          $display("FAIL gap_after_response: req=%b required 0", bus.mem_req_o);
        end
        resp_given = 1'b0;
      end
      if (bus.mem_req_o === 1'b1) begin
        if (prev_req !== 1'b1) begin
          cur_addr  = bus.mem_addr_o;
          cur_we    = bus.mem_we_o;
          cur_wdata = bus.mem_wdata_o;
          age       = 0;
          req_count++;
          checks++;
          if (bus.mem_be_o !== 4'hF) begin
            errors++;
            $display("FAIL byte_enable: be=%h required f", bus.mem_be_o);
          end
          obs = {cur_we, cur_addr, (cur_we ? cur_wdata : 32'h0)};
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_txn: got we=%b addr=%h data=%h, none required",
                     cur_we, cur_addr, cur_wdata);
          end else begin
            exp = exp_q.pop_front();
            if (obs !== exp) begin
              errors++;
              $display("FAIL txn: got we=%b addr=%h data=%h required we=%b addr=%h data=%h",
                       obs[64], obs[63:32], obs[31:0], exp[64], exp[63:32], exp[31:0]);
            end
          end
        end else begin
          age++;
          checks++;
          if ({bus.mem_addr_o, bus.mem_we_o, bus.mem_be_o, bus.mem_wdata_o} !==
              {cur_addr, cur_we, 4'hF, cur_wdata}) begin
            errors++;
            $display("FAIL stable_request: addr=%h we=%b be=%h wdata=%h required addr=%h we=%b be=f wdata=%h",
                     bus.mem_addr_o, bus.mem_we_o, bus.mem_be_o, bus.mem_wdata_o,
                     cur_addr, cur_we, cur_wdata);
          end
        end
        if (!silent && age == resp_delay) begin
          if (inject && cur_we && cur_addr == inj_addr) begin
            bus.mem_err_i = 1'b1;
          end else begin
            bus.mem_rvalid_i = 1'b1;
            if (!cur_we) bus.mem_rdata_i = rd_base_data + ((cur_addr - rd_base_addr) >> 2);
          end
          resp_given = 1'b1;
        end
      end
      prev_req = bus.mem_req_o;
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1; start is sampled on the next edge (cycle 0) and the
  // task returns at cycle 1 (+1).
  task automatic do_start(input logic [31:0] s, input logic [31:0] d, input logic [10:0] n);
    src_addr   = s;
    dst_addr   = d;
    word_count = n;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Returns the cycle index (1 = first cycle after start) at which done or
  // error is seen, or -1 if the budget runs out.
  task automatic wait_done_or_err(input int max_cycles, output int n);
    n = 1;
    while (done !== 1'b1 && error !== 1'b1 && n < max_cycles) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (done !== 1'b1 && error !== 1'b1) n = -1;
  endtask

  task automatic idle_cycles(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    idle_cycles(3);
    checks++;
    if ({busy, done, error, err_addr} !== 35'h0) begin
      errors++;
      $display("FAIL reset_status: busy=%b done=%b error=%b err_addr=%h required all 0",
               busy, done, error, err_addr);
    end
    checks++;
    if ({bus.mem_req_o, bus.mem_addr_o, bus.mem_we_o, bus.mem_be_o, bus.mem_wdata_o} !== 70'h0) begin
      errors++;
      $display("FAIL reset_bus: req=%b addr=%h we=%b be=%h wdata=%h required all 0",
               bus.mem_req_o, bus.mem_addr_o, bus.mem_we_o, bus.mem_be_o, bus.mem_wdata_o);
    end
    checks++;
    if (dbg_state !== 3'd0) begin
      errors++;
      $display("FAIL reset_state: state=%0d required 0", dbg_state);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    idle_cycles(1);
    checks++;
    if (busy !== 1'b0 || bus.mem_req_o !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: busy=%b req=%b required 0 0", busy, bus.mem_req_o);
    end
  endtask

  task automatic test_copy4;
    int n;
    int d0;
    d0 = done_cnt;
    resp_delay   = 3;
    rd_base_addr = 32'h0000_2000;
    rd_base_data = 32'h0000_00A0;
    for (int i = 0; i < 4; i++) begin
      push_rd(32'h0000_2000 + 32'(4 * i));
      push_wr(32'h0000_1000 + 32'(4 * i), 32'h0000_00A0 + 32'(i));
    end
    do_start(32'h0000_2000, 32'h0000_1000, 11'd4);
    checks++;
    if (busy !== 1'b1 || bus.mem_req_o !== 1'b1 || bus.mem_we_o !== 1'b0) begin
      errors++;
      $display("FAIL copy4_cycle1: busy=%b req=%b we=%b required 1 1 0",
               busy, bus.mem_req_o, bus.mem_we_o);
    end
    wait_done_or_err(200, n);
    // 8 transactions, each 4 request cycles plus 1 gap
    checks++;
    if (n !== 40) begin
      errors++;
      $display("FAIL copy4_done_cycle: got %0d required 40", n);
    end
    checks++;
    if (busy !== 1'b0 || error !== 1'b0) begin
      errors++;
      $display("FAIL copy4_done_status: busy=%b error=%b required 0 0", busy, error);
    end
    idle_cycles(4);
    checks++;
    if (done_cnt - d0 !== 1) begin
      errors++;
      $display("FAIL copy4_done_pulses: got %0d required 1", done_cnt - d0);
    end
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL copy4_missing_txns: got %0d left required 0", exp_q.size());
    end
  endtask

  task automatic test_zero_wait;
    int n;
    int cnt;
    cnt          = $urandom_range(2, 6);
    resp_delay   = 0;
    rd_base_addr = 32'h0000_2400;
    rd_base_data = 32'h0000_0300;
    for (int i = 0; i < cnt; i++) begin
      push_rd(32'h0000_2400 + 32'(4 * i));
      push_wr(32'h0000_1400 + 32'(4 * i), 32'h0000_0300 + 32'(i));
    end
    do_start(32'h0000_2400, 32'h0000_1400, 11'(cnt));
    wait_done_or_err(100, n);
    checks++;
    if (n !== 4 * cnt) begin
      errors++;
      $display("FAIL zero_wait_done_cycle: got %0d required %0d", n, 4 * cnt);
    end
    checks++;
    if (busy !== 1'b0 || error !== 1'b0) begin
      errors++;
      $display("FAIL zero_wait_status: busy=%b error=%b required 0 0", busy, error);
    end
    idle_cycles(3);
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL zero_wait_missing_txns: got %0d left required 0", exp_q.size());
    end
  endtask

  task automatic test_zero_count;
    int r0;
    r0 = req_count;
    do_start(32'h0000_2000, 32'h0000_1000, 11'd0);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || bus.mem_req_o !== 1'b0) begin
      errors++;
      $display("FAIL zero_count_cycle1: done=%b busy=%b req=%b required 1 0 0",
               done, busy, bus.mem_req_o);
    end
    idle_cycles(1);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL zero_count_pulse_width: done=%b required 0", done);
    end
    idle_cycles(3);
    checks++;
    if (req_count - r0 !== 0) begin
      errors++;
      $display("FAIL zero_count_requests: got %0d required 0", req_count - r0);
    end
  endtask

  task automatic test_misaligned;
    int r0;
    int n;
    r0 = req_count;
    do_start(32'h0000_2002, 32'h0000_1000, 11'd2);
    checks++;
    if (error !== 1'b1 || err_addr !== 32'h0000_2002 || bus.mem_req_o !== 1'b0) begin
      errors++;
      $display("FAIL misaligned_src: error=%b err_addr=%h req=%b required 1 00002002 0",
               error, err_addr, bus.mem_req_o);
    end
    idle_cycles(3);
    do_start(32'h0000_2000, 32'h0000_1001, 11'd1);
    checks++;
    if (error !== 1'b1 || err_addr !== 32'h0000_1001) begin
      errors++;
      $display("FAIL misaligned_dst: error=%b err_addr=%h required 1 00001001", error, err_addr);
    end
    idle_cycles(3);
    checks++;
    if (req_count - r0 !== 0) begin
      errors++;
      $display("FAIL misaligned_requests: got %0d required 0", req_count - r0);
    end
    checks++;
    if (error !== 1'b1) begin
      errors++;
      $display("FAIL error_sticky: error=%b required 1", error);
    end
    resp_delay   = 1;
    rd_base_addr = 32'h0000_2000;
    rd_base_data = 32'h0000_00C0;
    push_rd(32'h0000_2000);
    push_wr(32'h0000_1000, 32'h0000_00C0);
    do_start(32'h0000_2000, 32'h0000_1000, 11'd1);
    checks++;
    if (error !== 1'b0) begin
      errors++;
      $display("FAIL error_cleared_by_start: error=%b required 0", error);
    end
    wait_done_or_err(50, n);
    checks++;
    if (n < 0 || done !== 1'b1 || error !== 1'b0) begin
      errors++;
      $display("FAIL recover_copy: n=%0d done=%b error=%b required done 1 error 0", n, done, error);
    end
    idle_cycles(3);
  endtask

  task automatic test_bus_error;
    int n;
    int r0;
    int d0;
    resp_delay   = $urandom_range(0, 2);
    rd_base_addr = 32'h0000_3000;
    rd_base_data = 32'h0000_5500;
    inject       = 1'b1;
    inj_addr     = 32'h0000_1004;
    push_rd(32'h0000_3000);
    push_wr(32'h0000_1000, 32'h0000_5500);
    push_rd(32'h0000_3004);
    push_wr(32'h0000_1004, 32'h0000_5501);
    r0 = req_count;
    d0 = done_cnt;
    do_start(32'h0000_3000, 32'h0000_1000, 11'd3);
    wait_done_or_err(100, n);
    checks++;
    if (error !== 1'b1 || err_addr !== 32'h0000_1004) begin
      errors++;
      $display("FAIL bus_err_report: error=%b err_addr=%h required 1 00001004", error, err_addr);
    end
    checks++;
    if (bus.mem_req_o !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL bus_err_abort: req=%b busy=%b done=%b required 0 0 0",
               bus.mem_req_o, busy, done);
    end
    idle_cycles(20);
    inject = 1'b0;
    checks++;
    if (req_count - r0 !== 4 || done_cnt - d0 !== 0) begin
      errors++;
      $display("FAIL bus_err_traffic: requests=%0d dones=%0d required 4 0",
               req_count - r0, done_cnt - d0);
    end
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL bus_err_missing_txns: got %0d left required 0", exp_q.size());
    end
  endtask

  task automatic test_silent;
    int h0;
    silent = 1'b1;
    push_rd(32'h0000_4000);
    h0 = req_hi_cnt;
`ifdef MEM_COPY_TIMEOUT_EN
    begin
      int n;
      do_start(32'h0000_4000, 32'h0000_1000, 11'd1);
      wait_done_or_err(60, n);
      checks++;
      if (n !== 17 || error !== 1'b1 || err_addr !== 32'h0000_4000) begin
        errors++;
        $display("FAIL timeout: cycle=%0d error=%b err_addr=%h required 17 1 00004000",
                 n, error, err_addr);
      end
      idle_cycles(3);
      checks++;
      if (req_hi_cnt - h0 !== 16) begin
        errors++;
        $display("FAIL timeout_req_cycles: got %0d required 16", req_hi_cnt - h0);
      end
    end
`else
    begin
      int bad;
      bad = 0;
      do_start(32'h0000_4000, 32'h0000_1000, 11'd1);
      for (int i = 0; i < 1000; i++) begin
        if (bus.mem_req_o !== 1'b1 || error !== 1'b0 || done !== 1'b0) bad++;
        @(posedge clk);
        #1;
      end
      checks++;
      if (bad !== 0 || req_hi_cnt - h0 < 1000) begin
        errors++;
        $display("FAIL silent_wait: bad_cycles=%0d req_cycles=%0d required 0 and >=1000",
                 bad, req_hi_cnt - h0);
      end
      #3;
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
    end
`endif
    silent = 1'b0;
    idle_cycles(2);
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL silent_missing_txns: got %0d left required 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid_write;
    int n;
    int k;
    resp_delay   = 4;
    rd_base_addr = 32'h0000_2000;
    rd_base_data = 32'h0000_0E00;
    push_rd(32'h0000_2000);
    push_wr(32'h0000_1000, 32'h0000_0E00);
    do_start(32'h0000_2000, 32'h0000_1000, 11'd2);
    k = 0;
    while (!(bus.mem_req_o === 1'b1 && bus.mem_we_o === 1'b1) && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    checks++;
    if (k >= 50) begin
      errors++;
      $display("FAIL mid_write_reach: write request not seen in %0d cycles", k);
    end
    #3;
    rst = 1'b0;
    #1;
    checks++;
    if ({busy, done, error, err_addr, bus.mem_req_o, bus.mem_addr_o, bus.mem_we_o,
         bus.mem_be_o, bus.mem_wdata_o} !== 105'h0) begin
      errors++;
      $display("FAIL async_reset: busy=%b done=%b error=%b req=%b addr=%h we=%b be=%h wdata=%h required all 0",
               busy, done, error, bus.mem_req_o, bus.mem_addr_o, bus.mem_we_o,
               bus.mem_be_o, bus.mem_wdata_o);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL pre_reset_txns: got %0d left required 0", exp_q.size());
    end
    resp_delay   = 2;
    rd_base_addr = 32'h0000_2100;
    rd_base_data = 32'h0000_0077;
    for (int i = 0; i < 2; i++) begin
      push_rd(32'h0000_2100 + 32'(4 * i));
      push_wr(32'h0000_1200 + 32'(4 * i), 32'h0000_0077 + 32'(i));
    end
    do_start(32'h0000_2100, 32'h0000_1200, 11'd2);
    wait_done_or_err(100, n);
    checks++;
    if (n !== 16 || done !== 1'b1 || error !== 1'b0) begin
      errors++;
      $display("FAIL after_reset_copy: cycle=%0d done=%b error=%b required 16 1 0", n, done, error);
    end
    idle_cycles(3);
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL after_reset_missing_txns: got %0d left required 0", exp_q.size());
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    src_addr   = '0;
    dst_addr   = '0;
    word_count = '0;
    #2;
    rst = 1'b0;
    test_reset();
    test_copy4();
    test_zero_wait();
    test_zero_count();
    test_misaligned();
    test_bus_error();
    test_silent();
    test_reset_mid_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_copy_engine.md
# mem_copy_engine

Bus-initiator block that copies a block of words from one address to another over the Vicuna/Ibex-style memory request interface (`req`/`addr`/`we`/`be`/`wdata` out; `rvalid`/`err`/`rdata` in). It sits on the initiator side of the MMU, alongside the core, and drives the same memory map. Its main use is the boot copy from external storage (0x0000_2000 and up) into SRAM scratch (0x0000_1000–0x0000_1FFF). It issues strictly one transaction at a time: a read, then a write, per word.

## Interface
- `MEM_W`, 32: memory bus width in bits; the address step is MEM_W/8.
- `TIMEOUT_CYCLES`, 256: maximum cycles `mem_req_o` stays high awaiting a response. Used only with the timeout feature (see Configuration).
- `clk` input 1: single clock. All state updates on posedge.
- `rst` input 1: reset, **asynchronous, active-low**.
- `start` input 1: one-cycle pulse that launches a copy. Ignored while `busy` is high.
- `src_addr` input 32: source start address. Must be word-aligned.
- `dst_addr` input 32: destination start address. Must be word-aligned.
- `word_count` input 11: number of words to copy, 0–1024.
- `busy` output 1: high from the cycle after an accepted `start` until the completion cycle.
- `done` output 1: one-cycle pulse on successful completion.
- `error` output 1: sticky; cleared by the next accepted `start`.
- `err_addr` output 32: address of the failing transaction, or of the misaligned address.
- `mem_req_o` output 1: request.
- `mem_addr_o` output 32: request address.
- `mem_we_o` output 1: 1 = write, 0 = read.
- `mem_be_o` output MEM_W/8: byte enables; always all-ones during a request.
- `mem_wdata_o` output MEM_W: write data.
- `mem_rvalid_i` input 1: transaction complete. Carries read data on reads and acts as the acknowledge on writes.
- `mem_err_i` input 1: transaction failed.
- `mem_rdata_i` input MEM_W: read data, valid when `mem_rvalid_i` is high.

## Operation
- **Reset values:** all outputs 0; state IDLE; internal counters, data register and address registers 0.
- **States:** IDLE, READ, WRITE, GAP, FINISH, FAIL.
- **IDLE + start:**
  - Latch `src`, `dst` and `word_count`; clear `error`.
  - If either address has nonzero bits [1:0]: go to FAIL with `err_addr` = the offending address (src is checked first). No bus traffic occurs.
  - Else if `word_count` == 0: go to FINISH.
  - Else: go to READ.
- **READ:**
  - Drive `mem_req_o`=1, `mem_we_o`=0, `mem_addr_o`=src.
  - On `mem_rvalid_i`: capture `mem_rdata_i` into the data register; set next-op = WRITE; go to GAP.
- **WRITE:**
  - Drive `mem_req_o`=1, `mem_we_o`=1, `mem_addr_o`=dst, `mem_wdata_o`=data register.
  - On `mem_rvalid_i`:
    - src += MEM_W/8, dst += MEM_W/8, remaining -= 1.
    - If remaining reaches 0, go to FINISH.
    - Otherwise set next-op = READ and go to GAP.
- **GAP:** `mem_req_o`=0 for exactly one cycle, then go to next-op. This gives the responder a request-low cycle between transactions.
- **FINISH:** `done`=1 for one cycle; go to IDLE.
- **FAIL:** `error`=1, `err_addr` latched; go to IDLE (`error` stays high).
- **Errors on the bus:** `mem_err_i` in READ or WRITE → `err_addr` = current `mem_addr_o`, go to FAIL. `mem_err_i` takes priority when it arrives in the same cycle as `mem_rvalid_i`.
- **Stable request:** while `mem_req_o` is high, `mem_addr_o`, `mem_we_o`, `mem_be_o` and `mem_wdata_o` are held constant until a response arrives.
- **Addresses:** 32-bit wrap-around on increment is permitted and not flagged.
- **Reset mid-copy:** all outputs clear immediately (asynchronous); a partial copy is abandoned.

## Timing
- `start` accepted at cycle 0. `busy` is high at cycle 1 and `mem_req_o` (read) is high at cycle 1.
- Response at cycle N → `mem_req_o` low at N+1 → write request high at N+2.
- Per-word minimum with zero-wait responder: 4 cycles (read, gap, write, gap).
- After the final write's `mem_rvalid_i`: `done` pulses on the next cycle, and `busy` is low on that same cycle.
- `word_count`=0: `done` pulses at cycle 1.
- Misalignment: `error` high at cycle 1.
- `mem_rvalid_i`/`mem_err_i` are sampled only while `mem_req_o` is high; outside that they are ignored.

## Configuration
- `MEM_COPY_TIMEOUT_EN` defined:
  - A counter runs while `mem_req_o` is high and resets on every response or GAP.
  - When it reaches `TIMEOUT_CYCLES` with no response: `err_addr` = `mem_addr_o`, go to FAIL.
- Not defined: no counter; the block waits indefinitely for a response.

## Test plan
- src=0x0000_2000, dst=0x0000_1000, count=4; responder returns rvalid 3 cycles after req with rdata 0xA0+i. Required:
  - reads at 0x2000/0x2004/0x2008/0x200C;
  - writes of 0xA0–0xA3 to 0x1000–0x100C;
  - one req-low gap between each transaction;
  - be=0xF throughout;
  - a single `done` pulse; `error`=0.
- count=0 → `done` at cycle 1, `mem_req_o` never asserted, `busy` low at cycle 1.
- src=0x0000_2002 → `error`=1 at cycle 1, `err_addr`=0x0000_2002, no request issued. A following aligned `start` clears `error`.
- count=3; `mem_err_i` on the second write (0x1004) → `error`=1, `err_addr`=0x0000_1004, `mem_req_o` low on the next cycle, no further transactions, no `done`.
- Silent responder:
  - with `MEM_COPY_TIMEOUT_EN` and TIMEOUT_CYCLES=16 → `error` after 16 request cycles, `err_addr`=src;
  - without the macro → req held for 1000 cycles with no error.
- `rst` driven low mid-write (between clock edges) → all outputs 0 immediately. After release, a new `start` copies correctly from the new addresses.
